// File: rtl/ml_rowdrv_bank.sv
// ml_rowdrv_bank: CRAM row-driver bank with a one-hot row-select token and a write/read wordline sequencer.
// Latency: LOAD/INC/CLEAR/NOP take effect at the accepting edge; WRITE/READ pulse starts the cycle after acceptance.
// Backpressure: cmd_ready is high only in IDLE; it stays low through the whole pulse and its gap.
//
// Optional feature: define ML_ROWDRV_AUTOINC_EN to advance the token after each error-free WRITE.
//
// Ports:
//   smc_clk, smc_rst_b           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op   command handshake (0 NOP, 1 LOAD, 2 INC, 3 WRITE, 4 READ, 5 CLEAR)
//   cram_wl_en                   wordline enable, must remain high for a pulse to complete
//   cram_rst/vddoff/pgateoff     per-row controls applied to the selected row
//   por_rst                      power-on reset: forces every row_reset high and clears the token
//   wl_wr, wl_rd                 registered write/read wordlines
//   row_reset, vddctrl, pgate    per-row gating, combinational from the token
//   row_vld, row_idx             token present / position
//   rsr_out                      token shifted off the last row (chains to the next bank)
//   done, cmd_err                end of WRITE/READ, with error flag
module ml_rowdrv_bank #(
    parameter int ROWS    = 16,
    parameter int WR_CYC  = 4,
    parameter int RD_CYC  = 2,
    parameter int GAP_CYC = 1,
    localparam int IW     = $clog2(ROWS)
) (
    input  logic            smc_clk,
    input  logic            smc_rst_b,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic            cram_wl_en,
    input  logic            cram_rst,
    input  logic            cram_vddoff,
    input  logic            cram_pgateoff,
    input  logic            por_rst,
    output logic [ROWS-1:0] wl_wr,
    output logic [ROWS-1:0] wl_rd,
    output logic [ROWS-1:0] row_reset,
    output logic [ROWS-1:0] vddctrl,
    output logic [ROWS-1:0] pgate,
    output logic            row_vld,
    output logic [IW-1:0]   row_idx,
    output logic            rsr_out,
    output logic            done,
    output logic            cmd_err
);

    localparam int MAXC = (WR_CYC > RD_CYC) ? ((WR_CYC > GAP_CYC) ? WR_CYC : GAP_CYC)
                                            : ((RD_CYC > GAP_CYC) ? RD_CYC : GAP_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_INC   = 3'd2;
    localparam logic [2:0] OP_WRITE = 3'd3;
    localparam logic [2:0] OP_READ  = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd5;

    typedef enum logic [1:0] {IDLE, ACT, GAP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [ROWS-1:0] tok;
    logic            err;
`ifdef ML_ROWDRV_AUTOINC_EN
    logic            is_wr;
`endif

    always_ff @(posedge smc_clk or negedge smc_rst_b) begin
        if (!smc_rst_b) begin
            state   <= IDLE;
            cnt     <= '0;
            tok     <= '0;
            err     <= 1'b0;
            wl_wr   <= '0;
            wl_rd   <= '0;
            rsr_out <= 1'b0;
`ifdef ML_ROWDRV_AUTOINC_EN
            is_wr   <= 1'b0;
`endif
        end else begin
            rsr_out <= 1'b0;
            case (state)
                IDLE: begin
                    // cmd_ready is high in IDLE, so cmd_valid alone means a transfer
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_LOAD:  if (!por_rst) tok <= ROWS'(1);
                            OP_INC: begin
                                tok     <= tok << 1;
                                rsr_out <= tok[ROWS-1];
                            end
                            OP_CLEAR: tok <= '0;
                            OP_WRITE, OP_READ: begin
`ifdef ML_ROWDRV_AUTOINC_EN
                                is_wr <= (cmd_op == OP_WRITE);
`endif
                                if (row_vld && cram_wl_en && !por_rst) begin
                                    state <= ACT;
                                    err   <= 1'b0;
                                    if (cmd_op == OP_WRITE) begin
                                        wl_wr <= tok;
                                        cnt   <= CW'(WR_CYC - 1);
                                    end else begin
                                        wl_rd <= tok;
                                        cnt   <= CW'(RD_CYC - 1);
                                    end
                                end else begin
                                    // Pulse never starts; still run the gap so done has a fixed place
                                    state <= GAP;
                                    err   <= 1'b1;
                                    cnt   <= CW'(GAP_CYC - 1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ACT: begin
                    if (por_rst || !cram_wl_en || cnt == '0) begin
                        wl_wr <= '0;
                        wl_rd <= '0;
                        state <= GAP;
                        cnt   <= CW'(GAP_CYC - 1);
                        err   <= por_rst || !cram_wl_en;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
`ifdef ML_ROWDRV_AUTOINC_EN
                        if (is_wr && !err) begin
                            tok     <= tok << 1;
                            rsr_out <= tok[ROWS-1];
                        end
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Power-on reset overrides every token move decided above
            if (por_rst) begin
                tok     <= '0;
                rsr_out <= 1'b0;
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign done      = (state == GAP) && (cnt == '0);
    assign cmd_err   = done && err;
    assign row_vld   = |tok;

    // Token is one-hot, so OR-ing the indices of set bits yields its position
    always_comb begin
        row_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (tok[i]) row_idx = row_idx | IW'(i);
        end
    end

    assign row_reset = {ROWS{por_rst}} | (tok & {ROWS{cram_rst}});
    assign vddctrl   = tok & {ROWS{cram_vddoff}};
    assign pgate     = tok & {ROWS{cram_pgateoff}};

endmodule

// File: tb/tb_ml_rowdrv_bank.sv
// tb_ml_rowdrv_bank: directed checks of ml_rowdrv_bank with ROWS=16, WR_CYC=4, RD_CYC=2, GAP_CYC=1.
// Inputs are driven and outputs sampled 2 time units after the rising edge.
// Expected token movement after WRITE depends on ML_ROWDRV_AUTOINC_EN.
module tb_ml_rowdrv_bank;

    logic        smc_clk = 1'b0;
    logic        smc_rst_b;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic        cram_wl_en, cram_rst, cram_vddoff, cram_pgateoff, por_rst;
    logic [15:0] wl_wr, wl_rd, row_reset, vddctrl, pgate;
    logic        row_vld;
    logic [3:0]  row_idx;
    logic        rsr_out, done, cmd_err;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef ML_ROWDRV_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    ml_rowdrv_bank #(.ROWS(16), .WR_CYC(4), .RD_CYC(2), .GAP_CYC(1)) dut (
        .smc_clk(smc_clk), .smc_rst_b(smc_rst_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cram_wl_en(cram_wl_en), .cram_rst(cram_rst), .cram_vddoff(cram_vddoff),
        .cram_pgateoff(cram_pgateoff), .por_rst(por_rst),
        .wl_wr(wl_wr), .wl_rd(wl_rd), .row_reset(row_reset), .vddctrl(vddctrl), .pgate(pgate),
        .row_vld(row_vld), .row_idx(row_idx), .rsr_out(rsr_out), .done(done), .cmd_err(cmd_err)
    );

    always #5 smc_clk = ~smc_clk;

    task automatic tick();
        @(posedge smc_clk);
        #2;
    endtask

    // Offer a command for one cycle; returns in the cycle after the accepting edge
    task automatic send(input logic [2:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
    endtask

    task automatic test_reset();
        smc_rst_b = 1'b0;
        tick();
        tick();
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_chk++; if ({wl_wr, wl_rd} !== 32'h0) begin n_fail++; $display("FAIL reset_wl: got %h want 0", {wl_wr, wl_rd}); end
        n_chk++; if ({row_vld, row_idx, rsr_out, done, cmd_err} !== 8'h0) begin n_fail++;
            $display("FAIL reset_flags: got %b want 0", {row_vld, row_idx, rsr_out, done, cmd_err}); end
        n_chk++; if ({row_reset, vddctrl, pgate} !== 48'h0) begin n_fail++;
            $display("FAIL reset_rowctl: got %h want 0", {row_reset, vddctrl, pgate}); end
        smc_rst_b = 1'b1;
        tick();
        n_chk++; if (cmd_ready !== 1'b1 || row_vld !== 1'b0) begin n_fail++;
            $display("FAIL post_reset: ready=%b vld=%b want 1 0", cmd_ready, row_vld); end
    endtask

    task automatic test_write();
        send(3'd1);
        n_chk++; if (row_vld !== 1'b1 || row_idx !== 4'd0) begin n_fail++;
            $display("FAIL load: vld=%b idx=%0d want 1 0", row_vld, row_idx); end
        send(3'd3);
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (wl_wr !== 16'h0001 || wl_rd !== 16'h0 || cmd_ready !== 1'b0 || done !== 1'b0) begin n_fail++;
                $display("FAIL write_act%0d: wr=%h rd=%h rdy=%b done=%b want 0001 0000 0 0", k, wl_wr, wl_rd, cmd_ready, done); end
            tick();
        end
        n_chk++; if (wl_wr !== 16'h0 || done !== 1'b1 || cmd_err !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++;
            $display("FAIL write_gap: wr=%h done=%b err=%b rdy=%b want 0000 1 0 0", wl_wr, done, cmd_err, cmd_ready); end
        tick();
        n_chk++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_fail++;
            $display("FAIL write_idle: rdy=%b done=%b want 1 0", cmd_ready, done); end
        n_chk++; if (row_idx !== (AUTOINC ? 4'd1 : 4'd0) || row_vld !== 1'b1) begin n_fail++;
            $display("FAIL write_tok: idx=%0d vld=%b want %0d 1", row_idx, row_vld, AUTOINC ? 1 : 0); end
    endtask

    task automatic test_inc_chain();
        send(3'd1);
        for (int k = 0; k < 15; k++) send(3'd2);
        n_chk++; if (row_idx !== 4'd15 || row_vld !== 1'b1 || rsr_out !== 1'b0) begin n_fail++;
            $display("FAIL inc15: idx=%0d vld=%b rsr=%b want 15 1 0", row_idx, row_vld, rsr_out); end
        send(3'd2);
        n_chk++; if (rsr_out !== 1'b1 || row_vld !== 1'b0 || row_idx !== 4'd0) begin n_fail++;
            $display("FAIL inc_off: rsr=%b vld=%b idx=%0d want 1 0 0", rsr_out, row_vld, row_idx); end
        tick();
        n_chk++; if (rsr_out !== 1'b0) begin n_fail++; $display("FAIL rsr_pulse: rsr=%b want 0", rsr_out); end
        send(3'd3);
        n_chk++; if (wl_wr !== 16'h0 || done !== 1'b1 || cmd_err !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++;
            $display("FAIL write_notok: wr=%h done=%b err=%b rdy=%b want 0000 1 1 0", wl_wr, done, cmd_err, cmd_ready); end
        tick();
        n_chk++; if (cmd_ready !== 1'b1 || done !== 1'b0 || row_vld !== 1'b0) begin n_fail++;
            $display("FAIL notok_idle: rdy=%b done=%b vld=%b want 1 0 0", cmd_ready, done, row_vld); end
    endtask

    task automatic test_read();
        send(3'd1);
        for (int k = 0; k < 3; k++) send(3'd2);
        send(3'd4);
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (wl_rd !== 16'h0008 || wl_wr !== 16'h0 || done !== 1'b0) begin n_fail++;
                $display("FAIL read_act%0d: rd=%h wr=%h done=%b want 0008 0000 0", k, wl_rd, wl_wr, done); end
            tick();
        end
        n_chk++; if (wl_rd !== 16'h0 || wl_wr !== 16'h0 || done !== 1'b1 || cmd_err !== 1'b0) begin n_fail++;
            $display("FAIL read_gap: rd=%h wr=%h done=%b err=%b want 0000 0000 1 0", wl_rd, wl_wr, done, cmd_err); end
        tick();
        n_chk++; if (row_idx !== 4'd3 || cmd_ready !== 1'b1) begin n_fail++;
            $display("FAIL read_tok: idx=%0d rdy=%b want 3 1", row_idx, cmd_ready); end
    endtask

    task automatic test_abort();
        send(3'd1);
        send(3'd3);
        n_chk++; if (wl_wr !== 16'h0001) begin n_fail++; $display("FAIL abort_act1: wr=%h want 0001", wl_wr); end
        tick();
        n_chk++; if (wl_wr !== 16'h0001) begin n_fail++; $display("FAIL abort_act2: wr=%h want 0001", wl_wr); end
        cram_wl_en = 1'b0;
        tick();
        cram_wl_en = 1'b1;
        n_chk++; if (wl_wr !== 16'h0 || done !== 1'b1 || cmd_err !== 1'b1) begin n_fail++;
            $display("FAIL abort_gap: wr=%h done=%b err=%b want 0000 1 1", wl_wr, done, cmd_err); end
        tick();
        n_chk++; if (cmd_ready !== 1'b1 || row_idx !== 4'd0 || row_vld !== 1'b1) begin n_fail++;
            $display("FAIL abort_tok: rdy=%b idx=%0d vld=%b want 1 0 1", cmd_ready, row_idx, row_vld); end
    endtask

    task automatic test_rowctl();
        send(3'd1);
        for (int k = 0; k < 5; k++) send(3'd2);
        cram_vddoff = 1'b1;
        #1;
        n_chk++; if (vddctrl !== 16'h0020 || pgate !== 16'h0 || row_reset !== 16'h0) begin n_fail++;
            $display("FAIL vddoff: vdd=%h pg=%h rst=%h want 0020 0000 0000", vddctrl, pgate, row_reset); end
        cram_pgateoff = 1'b1;
        cram_rst      = 1'b1;
        #1;
        n_chk++; if (pgate !== 16'h0020 || row_reset !== 16'h0020) begin n_fail++;
            $display("FAIL pg_rst: pg=%h rst=%h want 0020 0020", pgate, row_reset); end
        cram_rst = 1'b0;
        por_rst  = 1'b1;
        #1;
        n_chk++; if (row_reset !== 16'hFFFF || row_vld !== 1'b1) begin n_fail++;
            $display("FAIL por_comb: rst=%h vld=%b want ffff 1", row_reset, row_vld); end
        tick();
        n_chk++; if (row_vld !== 1'b0 || vddctrl !== 16'h0 || row_reset !== 16'hFFFF) begin n_fail++;
            $display("FAIL por_tok: vld=%b vdd=%h rst=%h want 0 0000 ffff", row_vld, vddctrl, row_reset); end
        send(3'd1);
        n_chk++; if (row_vld !== 1'b0) begin n_fail++; $display("FAIL por_load: vld=%b want 0", row_vld); end
        por_rst       = 1'b0;
        cram_vddoff   = 1'b0;
        cram_pgateoff = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        send(3'd1);
        send(3'd3);
        n_chk++; if (wl_wr !== 16'h0001) begin n_fail++; $display("FAIL b2b_first: wr=%h want 0001", wl_wr); end
        for (int k = 0; k < 5; k++) tick();
        send(3'd3);
        n_chk++; if (wl_wr !== (AUTOINC ? 16'h0002 : 16'h0001)) begin n_fail++;
            $display("FAIL b2b_second: wr=%h want %h", wl_wr, AUTOINC ? 16'h0002 : 16'h0001); end
        for (int k = 0; k < 5; k++) tick();
        n_chk++; if (row_idx !== (AUTOINC ? 4'd2 : 4'd0) || cmd_ready !== 1'b1) begin n_fail++;
            $display("FAIL b2b_tok: idx=%0d rdy=%b want %0d 1", row_idx, cmd_ready, AUTOINC ? 2 : 0); end
    endtask

    task automatic test_reset_mid();
        send(3'd1);
        send(3'd3);
        n_chk++; if (wl_wr !== 16'h0001) begin n_fail++; $display("FAIL mid_act: wr=%h want 0001", wl_wr); end
        smc_rst_b = 1'b0;
        #1;
        n_chk++; if (wl_wr !== 16'h0 || row_vld !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin n_fail++;
            $display("FAIL mid_reset: wr=%h vld=%b rdy=%b done=%b want 0000 0 1 0", wl_wr, row_vld, cmd_ready, done); end
        tick();
        smc_rst_b = 1'b1;
        tick();
    endtask

    initial begin
        smc_rst_b = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0;
        cram_wl_en = 1'b1; cram_rst = 1'b0; cram_vddoff = 1'b0; cram_pgateoff = 1'b0; por_rst = 1'b0;
        test_reset();
        test_write();
        test_inc_chain();
        test_read();
        test_abort();
        test_rowctl();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
